// File: rtl/mac_dot_sched.sv
// Frames a ready/valid element stream into dot products on an external signed MAC.
// It clears the MAC between vectors and returns each sum and its element count on a one-entry result port.
module mac_dot_sched #(
  parameter int IN_W    = 10,
  parameter int F_W     = 20,
  parameter int CNT_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  s_a,
  input  logic signed [IN_W-1:0]  s_b,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic signed [IN_W-1:0]  mac_a,
  output logic signed [IN_W-1:0]  mac_b,
  output logic                    mac_valid_in,
  output logic                    mac_reset,
  input  logic signed [F_W-1:0]   mac_f,
  input  logic                    mac_valid_out,
  output logic signed [F_W-1:0]   m_data,
  output logic [CNT_W-1:0]        m_count,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {CLEAR, RUN, DRAIN, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [OW-1:0]    outstanding, outstanding_next;
  logic             accept, dec, final_sum, can_load, load;

  assign mac_a        = s_a;
  assign mac_b        = s_b;
  assign s_ready      = (state == RUN) && (outstanding != OW'(MAX_OUT));
  assign accept       = s_valid & s_ready;
  assign mac_valid_in = accept;
  assign mac_reset    = ~reset | (state == CLEAR);

  // A stray valid_out with nothing in flight must not underflow the counter.
  assign dec       = mac_valid_out && (outstanding != '0);
  assign final_sum = (state == DRAIN) && dec && (outstanding == OW'(1));
  assign can_load  = ~m_valid | m_ready;
  assign load      = (final_sum || (state == HOLD)) && can_load;

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    outstanding_next = outstanding + OW'(accept) - OW'(dec);
    case (state)
      CLEAR: begin
        state_next = RUN;
        cnt_next   = '0;
      end
      RUN: begin
        if (accept) begin
          if (cnt != '1) cnt_next = cnt + CNT_W'(1);
          if (s_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (final_sum) state_next = can_load ? CLEAR : HOLD;
      end
      HOLD: begin
        if (can_load) state_next = CLEAR;
      end
      default: state_next = CLEAR;
    endcase
  end

  // cnt freezes after the final accept, so it doubles as the latched vector length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      cnt         <= '0;
      outstanding <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      outstanding <= outstanding_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= mac_f;
      m_count <= cnt;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_dot_sched.sv
// Directed and randomised checks of mac_dot_sched against a two-stage behavioural MAC.
// Results are collected at the handshake and compared with hand-computed or model values.
module tb_mac_dot_sched;

  localparam int IN_W = 10, F_W = 20, CNT_W = 16, MAX_OUT = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [IN_W-1:0] s_a, s_b;
  logic                   s_valid, s_last, s_ready;
  logic signed [IN_W-1:0] mac_a, mac_b;
  logic                   mac_valid_in, mac_reset;
  logic signed [F_W-1:0]  mac_f;
  logic                   mac_valid_out;
  logic signed [F_W-1:0]  m_data;
  logic [CNT_W-1:0]       m_count;
  logic                   m_valid, m_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_dot_sched #(.IN_W(IN_W), .F_W(F_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_reset(mac_reset),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .m_data(m_data), .m_count(m_count), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Behavioural MAC: registered product, then accumulate; latency 2, sync clear.
  logic signed [F_W-1:0] prod_q, acc_q;
  logic                  v1_q, vo_q;
  always @(posedge clk) begin
    if (mac_reset) begin
      prod_q <= '0; acc_q <= '0; v1_q <= 1'b0; vo_q <= 1'b0;
    end else begin
      prod_q <= mac_a * mac_b;
      v1_q   <= mac_valid_in;
      vo_q   <= v1_q;
      if (v1_q) acc_q <= acc_q + prod_q;
    end
  end
  assign mac_f         = acc_q;
  assign mac_valid_out = vo_q;

  // Result capture, MAC pulse count and in-flight tracking.
  logic signed [F_W-1:0] got_data[$];
  logic [CNT_W-1:0]      got_count[$];
  int vi_cnt = 0, out_m = 0, max_out_seen = 0;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_count.push_back(m_count);
    end
    if (mac_valid_in) vi_cnt++;
    if (!reset) out_m = 0;
    else out_m = out_m + int'(mac_valid_in) - ((mac_valid_out && out_m > 0) ? 1 : 0);
    if (out_m > max_out_seen) max_out_seen = out_m;
  end

  int rd_idx = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input int b, input bit last);
    bit ok = 1'b0;
    s_a = a[IN_W-1:0]; s_b = b[IN_W-1:0]; s_last = last; s_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      ok = s_ready;
      cyc();
      if (ok) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic check_got(input string tag, input int exp_data, input int exp_count);
    int t = 0;
    while (got_data.size() <= rd_idx && t < 500) begin cyc(); t++; end
    if (got_data.size() <= rd_idx) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_data"}, $signed(got_data[rd_idx]), exp_data);
      chk({tag, "_count"}, got_count[rd_idx], exp_count);
      $display("result %s: data=%0d count=%0d", tag, got_data[rd_idx], got_count[rd_idx]);
      rd_idx++;
    end
  endtask

  task automatic wait_m_valid(input string tag);
    int t = 0;
    while (!m_valid && t < 100) begin cyc(); t++; end
    if (!m_valid) chk({tag, "_mvalid_timeout"}, 0, 1);
  endtask

  logic signed [F_W-1:0] exp_d[$];
  int                    exp_c[$];

  initial begin
    int base;
    bit done;
    reset = 1'b0; s_a = '0; s_b = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mac_reset", mac_reset, 1);
    reset = 1'b1;
    chk("clear_mac_reset", mac_reset, 1);
    chk("clear_s_ready", s_ready, 0);
    cyc();
    chk("run_s_ready", s_ready, 1);
    chk("run_mac_reset", mac_reset, 0);

    // Vector (1,1),(2,2),(3,3): 1+4+9 = 14
    send(1, 1, 0); send(2, 2, 0); send(3, 3, 1);
    chk("drain_s_ready", s_ready, 0);
    wait_m_valid("v1");
    chk("load_s_ready", s_ready, 0);
    cyc();
    chk("after_load_s_ready", s_ready, 1);
    chk("pulse_m_valid", m_valid, 0);
    check_got("v1", 14, 3);

    // Back to back: 6-20 = -14; 262144; 2*262144 wraps to -524288 in 20 bits
    send(2, 3, 0); send(4, -5, 1);
    send(-512, -512, 1);
    send(-512, -512, 0); send(-512, -512, 1);
    check_got("b2b_a", -14, 2);
    check_got("b2b_b", 262144, 1);
    check_got("b2b_wrap", -524288, 2);

    // Valid every other cycle: 4*25 = 100, exactly four MAC pulses
    base = vi_cnt;
    for (int i = 0; i < 4; i++) begin
      send(5, 5, i == 3);
      cyc();
    end
    check_got("gaps", 100, 4);
    chk("gaps_mac_pulses", vi_cnt - base, 4);

    // Consumer stalls: first result held, second vector parks in HOLD
    m_ready = 1'b0;
    send(1, 2, 1);
    send(3, 3, 0); send(1, 1, 1);
    repeat (10) cyc();
    chk("hold_m_valid", m_valid, 1);
    chk("hold_m_data", $signed(m_data), 2);
    chk("hold_m_count", m_count, 1);
    chk("hold_s_ready", s_ready, 0);
    m_ready = 1'b1;
    cyc();
    chk("hold_load_m_data", $signed(m_data), 10);
    chk("hold_load_m_count", m_count, 2);
    chk("hold_load_m_valid", m_valid, 1);
    chk("hold_load_s_ready", s_ready, 0);
    cyc();
    chk("hold_done_m_valid", m_valid, 0);
    chk("hold_done_s_ready", s_ready, 1);
    check_got("hold_a", 2, 1);
    check_got("hold_b", 10, 2);

    // Reset with a pending result and a partial vector in flight
    m_ready = 1'b0;
    send(9, 9, 1);
    wait_m_valid("pend");
    send(1, 1, 0); send(2, 2, 0);
    reset = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_mac_reset", mac_reset, 1);
    chk("midrst_s_ready", s_ready, 0);
    cyc();
    reset = 1'b1;
    m_ready = 1'b1;
    cyc();
    send(7, 7, 1);
    check_got("after_rst", 49, 1);

    // Random stream against a sum/count reference
    done = 1'b0;
    fork
      begin
        logic signed [F_W-1:0] acc = '0;
        int cnt = 0;
        for (int i = 0; i < 2000; i++) begin
          int a = int'($urandom_range(1023)) - 512;
          int b = int'($urandom_range(1023)) - 512;
          bit last = ($urandom_range(7) == 0) || (i == 1999);
          if ($urandom_range(3) == 0) cyc();
          acc = acc + F_W'(a * b);
          cnt++;
          if (last) begin
            exp_d.push_back(acc); exp_c.push_back(cnt);
            acc = '0; cnt = 0;
          end
          send(a, b, last);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready = 1'($urandom_range(1));
          cyc();
        end
        m_ready = 1'b1;
      end
    join
    for (int k = 0; k < exp_d.size(); k++) begin
      check_got($sformatf("rnd%0d", k), int'(exp_d[k]), exp_c[k]);
    end
    chk("max_outstanding_ok", (max_out_seen <= MAX_OUT), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
